// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the memory-game logic.
// Optional macro LOCK_LOSS_COUNT_EN adds the loss_count debug counter.
interface pll_lock_sequencer_if;
    logic       locked;
    logic       sys_rst;
    logic       ready;
    logic       tick;
    logic       lock_lost;
    logic [1:0] state;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    // The sequencer consumes the PLL lock and drives everything else.
    modport master (
        input  locked,
        output sys_rst,
        output ready,
        output tick,
        output lock_lost,
`ifdef LOCK_LOSS_COUNT_EN
        output loss_count,
`endif
        output state
    );

    modport slave (
        output locked,
        input  sys_rst,
        input  ready,
        input  tick,
        input  lock_lost,
`ifdef LOCK_LOSS_COUNT_EN
        input  loss_count,
`endif
        input  state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Qualifies PLL lock, sequences a clean system reset and generates the run-time tick.
// Optional macro LOCK_LOSS_COUNT_EN adds a saturating count of RUN-to-WAIT_LOCK drops.
module pll_lock_sequencer #(
    parameter int CLK_HZ          = 2000000,
    parameter int TICK_HZ         = 1000,
    parameter int STABLE_CYCLES   = 1024,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_sequencer_if.master bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int SW  = (STABLE_CYCLES   > 1) ? $clog2(STABLE_CYCLES)   : 1;
    localparam int HW  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          sync1, lk_s;
    logic [SW-1:0] stable_cnt, stable_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [DW-1:0] div_cnt, div_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          tick_q, tick_d;
    logic          lock_lost_q, lock_lost_d;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            lk_s        <= 1'b0;
            state_q     <= WAIT_LOCK;
            stable_cnt  <= '0;
            hold_cnt    <= '0;
            div_cnt     <= '0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            tick_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync1       <= bus.locked;
            lk_s        <= sync1;
            state_q     <= state_d;
            stable_cnt  <= stable_d;
            hold_cnt    <= hold_d;
            div_cnt     <= div_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            tick_q      <= tick_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Counters default to zero so each state entry starts from a clean count and
    // a lock drop always wins over a counter reaching its terminal value.
    always_comb begin
        state_d     = state_q;
        stable_d    = '0;
        hold_d      = '0;
        div_d       = '0;
        lock_lost_d = lock_lost_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lk_s) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!lk_s)                         state_d  = WAIT_LOCK;
                else if (stable_cnt == STABLE_LAST) state_d  = HOLD;
                else                               stable_d = stable_cnt + 1'b1;
            end
            HOLD: begin
                if (!lk_s)                     state_d = WAIT_LOCK;
                else if (hold_cnt == HOLD_LAST) state_d = RUN;
                else                           hold_d  = hold_cnt + 1'b1;
            end
            RUN: begin
                if (!lk_s) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (div_cnt != DIV_LAST) begin
                    div_d = div_cnt + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Outputs are registered from the next state, so they move on the same edge as state.
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        tick_d    = (state_d == RUN) && (div_d == DIV_LAST);
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_count_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_count_q <= 8'd0;
        end else if (state_q == RUN && !lk_s && loss_count_q != 8'hFF) begin
            loss_count_q <= loss_count_q + 8'd1;
        end
    end

    assign bus.loss_count = loss_count_q;
`endif

    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.tick      = tick_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with STABLE_CYCLES=8, RST_HOLD_CYCLES=4, DIV=10.
// Define LOCK_LOSS_COUNT_EN to also exercise loss_count and its saturation.
module tb_pll_lock_sequencer;

    localparam int STABLE = 8;
    localparam int HOLDC  = 4;
    localparam int DIV    = 10;
    // Edges from a locked change to the registered outputs: 2 sync flops plus the state register.
    localparam int SYNC_LAT = 3;
    localparam int RELEASE_LAT = 2 + STABLE + HOLDC + 1;

    logic refclk = 1'b0;
    logic rst;

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .CLK_HZ          (10000),
        .TICK_HZ         (1000),
        .STABLE_CYCLES   (STABLE),
        .RST_HOLD_CYCLES (HOLDC)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q[$];
    int tick_q[$];
    int exp_state_q[$];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic lk);
        bus.locked = lk;
    endtask

    // Steps until sys_rst releases, checking each state change against the scoreboard.
    task automatic run_to_ready(input string tag);
        int exp_cyc;
        int prev;
        int n;
        exp_cyc = exp_q.pop_front();
        prev = bus.state;
        n = 0;
        while (bus.sys_rst !== 1'b0 && n < 60) begin
            step();
            n++;
            if (bus.state != prev && exp_state_q.size() > 0)
                checkOutput({tag, "_state_seq"}, bus.state, exp_state_q.pop_front());
            prev = bus.state;
        end
        checkOutput({tag, "_release_cycle"}, cyc, exp_cyc);
        checkOutput({tag, "_ready"}, bus.ready, 1);
        checkOutput({tag, "_state_run"}, bus.state, 3);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int r0;
        int n_ticks;
        int g;
`ifdef LOCK_LOSS_COUNT_EN
        int model_loss;
        int sat_timeouts;
`endif
        rst = 1'b1;
        applyStimulus(1'b0);
        repeat (3) step();
        checkOutput("reset_sys_rst", bus.sys_rst, 1);
        checkOutput("reset_ready", bus.ready, 0);
        checkOutput("reset_tick", bus.tick, 0);
        checkOutput("reset_lock_lost", bus.lock_lost, 0);
        checkOutput("reset_state", bus.state, 0);

        rst = 1'b0;
        repeat (3) step();
        checkOutput("idle_state", bus.state, 0);
        checkOutput("idle_sys_rst", bus.sys_rst, 1);

        // Clean start: 0 -> 1 -> 2 -> 3.
        exp_state_q = '{1, 2, 3};
        applyStimulus(1'b1);
        exp_q.push_back(cyc + RELEASE_LAT);
        run_to_ready("clean");
        checkOutput("clean_seq_left", exp_state_q.size(), 0);

        // Tick cadence over 1000 RUN cycles; the current sample is RUN cycle 1.
        r0 = cyc;
        for (int k = 0; k < 100; k++) tick_q.push_back(r0 + DIV - 1 + DIV * k);
        checkOutput("tick_first_low", bus.tick, 0);
        n_ticks = 0;
        for (int i = 1; i < 1000; i++) begin
            step();
            if (bus.tick) begin
                n_ticks++;
                if (tick_q.size() > 0) checkOutput("tick_cycle", cyc, tick_q.pop_front());
                else checkOutput("tick_extra", cyc, 0);
            end
        end
        checkOutput("tick_count", n_ticks, 100);

        // Lock loss timed so the state change lands where the next tick would fire.
        repeat (7) step();
        applyStimulus(1'b0);
        exp_q.push_back(cyc + SYNC_LAT);
        n = 0;
        while (bus.sys_rst !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checkOutput("loss_cycle", cyc, exp_q.pop_front());
        checkOutput("loss_ready", bus.ready, 0);
        checkOutput("loss_tick_suppressed", bus.tick, 0);
        checkOutput("loss_lock_lost", bus.lock_lost, 1);
        checkOutput("loss_state", bus.state, 0);

        applyStimulus(1'b1);
        exp_q.push_back(cyc + RELEASE_LAT);
        run_to_ready("relock");
        checkOutput("relock_lock_lost", bus.lock_lost, 1);
`ifdef LOCK_LOSS_COUNT_EN
        checkOutput("relock_loss_count", bus.loss_count, 1);
`endif

        // Glitch in STABILIZE after 5 stable cycles restarts qualification.
        applyStimulus(1'b0);
        repeat (SYNC_LAT) step();
        checkOutput("glitch_pre_state", bus.state, 0);
        applyStimulus(1'b1);
        repeat (8) step();
        checkOutput("glitch_in_stab", bus.state, 1);
        applyStimulus(1'b0);
        step();
        applyStimulus(1'b1);
        g = cyc;
        exp_state_q = '{0, 1, 2, 3};
        exp_q.push_back(g + RELEASE_LAT);
        run_to_ready("glitch");
        checkOutput("glitch_seq_left", exp_state_q.size(), 0);

        // Asynchronous reset between edges while in RUN.
        step();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_sys_rst", bus.sys_rst, 1);
        checkOutput("arst_ready", bus.ready, 0);
        checkOutput("arst_tick", bus.tick, 0);
        checkOutput("arst_lock_lost", bus.lock_lost, 0);
        checkOutput("arst_state", bus.state, 0);
`ifdef LOCK_LOSS_COUNT_EN
        checkOutput("arst_loss_count", bus.loss_count, 0);
`endif
        step();
        rst = 1'b0;
        exp_state_q = '{1, 2, 3};
        exp_q.push_back(cyc + RELEASE_LAT);
        run_to_ready("rearm");
        checkOutput("rearm_lock_lost", bus.lock_lost, 0);

`ifdef LOCK_LOSS_COUNT_EN
        // Saturation: 260 RUN-to-loss cycles against a saturating model.
        model_loss = 0;
        sat_timeouts = 0;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0);
            n = 0;
            while (bus.state != 2'd0 && n < 10) begin step(); n++; end
            if (bus.state != 2'd0) sat_timeouts++;
            if (model_loss < 255) model_loss++;
            applyStimulus(1'b1);
            n = 0;
            while (bus.ready !== 1'b1 && n < 40) begin step(); n++; end
            if (bus.ready !== 1'b1) sat_timeouts++;
            if (i == 100) checkOutput("sat_mid", bus.loss_count, model_loss);
        end
        checkOutput("sat_timeouts", sat_timeouts, 0);
        checkOutput("sat_value", bus.loss_count, model_loss);
        repeat (5) step();
        checkOutput("sat_hold", bus.loss_count, 255);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
